mem_arbiter: RTL

- Shares the single-port system RAM between two requesters: the CPU memory interface (MAR/MDR path, driven by the microcoded decoder's M-cycles) and a DMA/boot-loader port.
- Fixed CPU priority, with a starvation guard that forces a DMA grant after a bounded number of contested CPU wins.
- Each transaction is latched, presented to RAM for RAM_LAT+1 cycles, and closed with a one-cycle ack pulse to the owner.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port system RAM between the CPU memory
// interface and a DMA/boot-loader port. The CPU has fixed priority; a
// bounded-wait counter forces a DMA grant after DMA_MAX_WAIT contested CPU
// wins. Each transaction is latched at grant, held on the RAM pins for
// RAM_LAT+1 cycles and closed with a one-cycle ack pulse to its owner.
//
// state   | meaning
// IDLE    | RAM free; arbitrate when neither ack is pulsing
// CPU_ACC | CPU transaction on the RAM pins, cnt counts beats 0..RAM_LAT
// DMA_ACC | DMA transaction on the RAM pins, cnt counts beats 0..RAM_LAT
module mem_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int RAM_LAT      = 1,
   parameter int DMA_MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      DMA_ACC = 2'd2
   } state_t;

   // Counter widths sized so RAM_LAT and DMA_MAX_WAIT are representable;
   // DMA_MAX_WAIT=0 still needs a one-bit counter that simply never moves.
   localparam int CW = (RAM_LAT < 1) ? 1 : $clog2(RAM_LAT + 1);
   localparam int WW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(RAM_LAT);
   localparam logic [WW-1:0] MAX_W = WW'(DMA_MAX_WAIT);

   state_t        st;
   logic [CW-1:0] cnt;
   logic [WW-1:0] wait_cnt;
   logic          we_lat;
   logic          arb_en;
   logic          pick_cpu;
   logic          pick_dma;
   logic          last_beat;

   assign state = st;

   // Arbitration decision; the ack holdoff gives a requester one cycle to
   // drop or change its request before it can be sampled again.
   always_comb begin
      arb_en    = (st == IDLE) && !cpu_ack && !dma_ack;
      pick_dma  = arb_en && dma_req && (!cpu_req || (wait_cnt == MAX_W));
      pick_cpu  = arb_en && cpu_req && !pick_dma;
      last_beat = (cnt == LAT_C);
   end

   // Arbiter FSM with registered grants, acks, RAM pins and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= IDLE;
         cnt       <= '0;
         wait_cnt  <= '0;
         we_lat    <= 1'b0;
         cpu_gnt   <= 1'b0;
         dma_gnt   <= 1'b0;
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         case (st)
            IDLE: begin
               cnt <= '0;
               if (arb_en) begin
                  // Only a CPU win over a waiting DMA counts toward the guard.
                  if (pick_dma || !dma_req) begin
                     wait_cnt <= '0;
                  end else if (pick_cpu && (wait_cnt != MAX_W)) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               if (pick_cpu) begin
                  st        <= CPU_ACC;
                  cpu_gnt   <= 1'b1;
                  we_lat    <= cpu_we;
                  ram_we    <= cpu_we;
                  ram_addr  <= cpu_addr;
                  ram_wdata <= cpu_wdata;
               end else if (pick_dma) begin
                  st        <= DMA_ACC;
                  dma_gnt   <= 1'b1;
                  we_lat    <= dma_we;
                  ram_we    <= dma_we;
                  ram_addr  <= dma_addr;
                  ram_wdata <= dma_wdata;
               end
            end
            CPU_ACC, DMA_ACC: begin
               // Write strobe lives only in beat 0; address/data stay put.
               ram_we <= 1'b0;
               cnt    <= cnt + 1'b1;
               if (last_beat) begin
                  if (!we_lat) begin
                     if (st == CPU_ACC) begin
                        cpu_rdata <= ram_rdata;
                     end else begin
                        dma_rdata <= ram_rdata;
                     end
                  end
                  if (st == CPU_ACC) begin
                     cpu_ack <= 1'b1;
                  end else begin
                     dma_ack <= 1'b1;
                  end
                  cpu_gnt   <= 1'b0;
                  dma_gnt   <= 1'b0;
                  ram_addr  <= '0;
                  ram_wdata <= '0;
                  st        <= IDLE;
               end
            end
            default: begin
               st        <= IDLE;
               cnt       <= '0;
               cpu_gnt   <= 1'b0;
               dma_gnt   <= 1'b0;
               ram_we    <= 1'b0;
               ram_addr  <= '0;
               ram_wdata <= '0;
            end
         endcase
      end
   end

endmodule
